usb_rx_pkt_decoder: RTL and testbench

Parametrised serial USB receive-packet decoder. Consumes the NRZI-decoded, bit-unstuffed bitstream (bstr/bstr_avail/bstr_done) from the receive front end. Strips SYNC, parses and checks the PID, then classifies the packet as token, data or handshake. Assembles the body, checks CRC5 or CRC16 on the fly, and presents one parallel packet record with valid/error status to the protocol FSM.

---
 rtl/usb_rx_pkt_decoder_if.sv | 24 ++
 rtl/usb_rx_pkt_decoder.sv | 133 +++++++++++++
 tb/tb_usb_rx_pkt_decoder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkt_decoder_if.sv
// usb_rx_pkt_decoder_if: unstuffed bitstream in, decoded packet record out
interface usb_rx_pkt_decoder_if #(
    parameter int MAX_DATA_BYTES = 64,
    parameter int LEN_W = 7
);
    logic bstr;
    logic bstr_avail;
    logic bstr_done;
    logic [3:0] pkt_pid;
    logic [10:0] pkt_token;
    logic [8*MAX_DATA_BYTES-1:0] pkt_data;
    logic [LEN_W-1:0] pkt_len;
    logic pkt_avail;
    logic pkt_valid;
    logic [2:0] pkt_err;
    modport master (
        output bstr, bstr_avail, bstr_done,
        input pkt_pid, pkt_token, pkt_data, pkt_len, pkt_avail, pkt_valid, pkt_err
    );
    modport slave (
        input bstr, bstr_avail, bstr_done,
        output pkt_pid, pkt_token, pkt_data, pkt_len, pkt_avail, pkt_valid, pkt_err
    );
endinterface

// File: rtl/usb_rx_pkt_decoder.sv
// usb_rx_pkt_decoder: serial USB packet decoder with CRC5/CRC16 check; USB_RX_STRICT_SYNC_EN checks the SYNC pattern
module usb_rx_pkt_decoder #(
    parameter int MAX_DATA_BYTES = 64,
    parameter int SYNC_BITS = 8,
    parameter int LEN_W = 7
) (
    input logic clk,
    input logic rst,
    usb_rx_pkt_decoder_if.slave bus
);
    localparam int DW = 8 * MAX_DATA_BYTES;
    localparam int LIM = 8 * (MAX_DATA_BYTES + 2);
    localparam int BW = $clog2(LIM + 1);
    localparam int IW = $clog2(DW);
    localparam int CW = $clog2(SYNC_BITS + 8);
`ifdef USB_RX_STRICT_SYNC_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SYNC, PID, BODY, DRAIN, REPORT} state_t;
    state_t state, nxt;

    logic av, dn, b, end_pkt, rep;
    logic [CW-1:0] cnt;
    logic [7:0] pid;
    logic [BW-1:0] nb;
    logic [15:0] dl, crc16;
    logic [4:0] crc5;
    logic [DW-1:0] dbuf;
    logic [IW-1:0] wi;
    logic pfull, sbad, abt, ovf;
    logic tok, dat, at_lim, pid_bad, len_bad, crc_bad;
    logic [2:0] err, h_err;
    logic [LEN_W-1:0] c_len, h_len;
    logic [10:0] c_tok, h_tok;
    logic [DW-1:0] c_data, h_data;
    logic [3:0] h_pid;
    logic h_val;

    assign av = bus.bstr_avail;
    assign dn = bus.bstr_done;
    assign b = bus.bstr;
    assign end_pkt = dn || !av;
    assign rep = state == REPORT;
    assign wi = IW'(nb - BW'(16));

    assign tok = pid[1:0] == 2'b01 || pid[3:0] == 4'b0100;
    assign dat = pid[1:0] == 2'b11;
    assign at_lim = nb == (tok ? BW'(16) : BW'(LIM));
    assign pid_bad = !pfull || pid[7:4] != ~pid[3:0];
    assign len_bad = ovf || nb[2:0] != 3'd0 || (tok ? nb != BW'(16) : dat ? nb < BW'(16) : nb != '0);
    assign crc_bad = tok ? crc5 != 5'b01100 : dat && crc16 != 16'h800D;
    assign err = abt ? 3'd4 : STRICT && sbad ? 3'd5 : pid_bad ? 3'd1 : len_bad ? 3'd3 : crc_bad ? 3'd2 : 3'd0;
    assign c_len = dat && nb >= BW'(16) ? LEN_W'((nb - BW'(16)) >> 3) : '0;
    assign c_tok = tok ? dl[10:0] : '0;
    assign c_data = dat ? dbuf : '0;

    assign bus.pkt_avail = rep;
    assign bus.pkt_err = rep ? err : h_err;
    assign bus.pkt_valid = rep ? err == 3'd0 : h_val;
    assign bus.pkt_pid = rep ? pid[3:0] : h_pid;
    assign bus.pkt_len = rep ? c_len : h_len;
    assign bus.pkt_token = rep ? c_tok : h_tok;
    assign bus.pkt_data = rep ? c_data : h_data;

    always_ff @(posedge clk) state <= rst ? IDLE : nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = av ? (SYNC_BITS == 1 ? PID : SYNC) : IDLE;
            SYNC: nxt = end_pkt ? REPORT : cnt == CW'(SYNC_BITS - 1) ? PID : SYNC;
            PID: nxt = end_pkt ? REPORT : cnt == CW'(7) ? BODY : PID;
            BODY: nxt = end_pkt ? REPORT : at_lim ? DRAIN : BODY;
            DRAIN: nxt = end_pkt ? REPORT : DRAIN;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {cnt, pid, nb, dl, crc16, crc5, pfull, sbad, abt, ovf} <= '0;
            dbuf <= '0;
            {h_err, h_val, h_pid, h_len, h_tok} <= '0;
            h_data <= '0;
        end else begin
            case (state)
                IDLE: if (av) begin
                    cnt <= CW'(SYNC_BITS != 1);
                    sbad <= b != (SYNC_BITS == 1);
                    {pid, nb, dl, pfull, abt, ovf} <= '0;
                    dbuf <= '0;
                end
                SYNC: if (av) begin
                    cnt <= cnt == CW'(SYNC_BITS - 1) ? '0 : cnt + 1'b1;
                    sbad <= sbad | (b != (cnt == CW'(SYNC_BITS - 1)));
                end
                PID: if (av) begin
                    pid <= {b, pid[7:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(7)) begin
                        pfull <= 1'b1;
                        crc5 <= '1;
                        crc16 <= '1;
                    end
                end
                BODY: if (av) begin
                    if (at_lim) ovf <= 1'b1;
                    else begin
                        nb <= nb + 1'b1;
                        // 16-bit delay line keeps the trailing CRC16 out of the payload
                        dl <= {b, dl[15:1]};
                        crc5 <= {crc5[3:0], 1'b0} ^ (crc5[4] ^ b ? 5'h05 : 5'h00);
                        crc16 <= {crc16[14:0], 1'b0} ^ (crc16[15] ^ b ? 16'h8005 : 16'h0000);
                        if (nb >= BW'(16)) dbuf[wi] <= dl[0];
                    end
                end
                REPORT: begin
                    h_err <= err;
                    h_val <= err == 3'd0;
                    h_pid <= pid[3:0];
                    h_len <= c_len;
                    h_tok <= c_tok;
                    h_data <= c_data;
                end
                default: ;
            endcase
            if (state inside {SYNC, PID, BODY, DRAIN} && !av && !dn) abt <= 1'b1;
        end
    end
endmodule

// File: tb/tb_usb_rx_pkt_decoder.sv
// tb_usb_rx_pkt_decoder: directed and random packets checked against a packet-level reference model
module tb_usb_rx_pkt_decoder;
    localparam int MDB = 8;
    localparam int LW = 4;
    localparam int DW = 8 * MDB;
`ifdef USB_RX_STRICT_SYNC_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int npulse = 0;
    bit body[$];
    logic [3:0] hs_p [4] = '{4'h2, 4'hA, 4'hE, 4'h6};
    logic [3:0] tk_p [5] = '{4'h1, 4'h9, 4'h5, 4'hD, 4'h4};
    logic [3:0] dt_p [4] = '{4'h3, 4'hB, 4'h7, 4'hF};

    usb_rx_pkt_decoder_if #(.MAX_DATA_BYTES(MDB), .LEN_W(LW)) bus();
    usb_rx_pkt_decoder #(.MAX_DATA_BYTES(MDB), .SYNC_BITS(8), .LEN_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(negedge clk) if (bus.pkt_avail) npulse++;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit a, input bit v, input bit d);
        @(negedge clk);
        bus.bstr_avail = a;
        bus.bstr = v;
        bus.bstr_done = d;
    endtask

    function automatic logic [15:0] lfsr(input bit c16, input int n);
        logic [15:0] r, m;
        m = c16 ? 16'hFFFF : 16'h001F;
        r = m;
        for (int i = 0; i < n; i++)
            r = ((r << 1) ^ (((c16 ? r[15] : r[4]) ^ body[i]) ? (c16 ? 16'h8005 : 16'h0005) : 16'h0000)) & m;
        return r;
    endfunction

    task automatic add_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) body.push_back(v[i]);
    endtask

    task automatic add_crc(input bit c16);
        logic [15:0] r;
        r = lfsr(c16, body.size());
        for (int i = c16 ? 15 : 4; i >= 0; i--) body.push_back(~r[i]);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ":err"}, DW'(bus.pkt_err), '0);
        chk({nm, ":valid"}, DW'(bus.pkt_valid), '0);
        chk({nm, ":pid"}, DW'(bus.pkt_pid), '0);
        chk({nm, ":len"}, DW'(bus.pkt_len), '0);
        chk({nm, ":token"}, DW'(bus.pkt_token), '0);
        chk({nm, ":data"}, bus.pkt_data, '0);
    endtask

    task automatic run_pkt(input string nm, input bit bsync, input logic [7:0] pb, input int cut);
        bit s[$];
        int n, e, st;
        bit tk, dt, jn;
        logic [DW-1:0] xd;
        logic [10:0] xt;
        n = body.size();
        tk = pb[1:0] == 2'b01 || pb[3:0] == 4'b0100;
        dt = pb[1:0] == 2'b11;
        e = cut >= 0 ? 4 : STRICT && bsync ? 5 : pb[7:4] != ~pb[3:0] ? 1 :
            (tk ? n != 16 : dt ? (n % 8 != 0 || n < 16 || n > 8 * (MDB + 2)) : n != 0) ? 3 :
            ((tk || dt) && lfsr(dt, n) != (dt ? 16'h800D : 16'h000C)) ? 2 : 0;
        xd = '0;
        xt = '0;
        if (dt && e == 0) for (int i = 0; i < n - 16; i++) xd[i] = body[i];
        if (tk && e == 0) for (int i = 0; i < 11; i++) xt[i] = body[i];
        for (int i = 0; i < 8; i++) s.push_back(bsync ? i >= 6 : i == 7);
        for (int i = 0; i < 8; i++) s.push_back(pb[i]);
        for (int i = 0; i < (cut >= 0 ? cut : n); i++) s.push_back(body[i]);
        jn = cut < 0 && $urandom_range(0, 1) == 1;
        st = npulse;
        foreach (s[i]) drive(1'b1, s[i], jn && i == s.size() - 1);
        if (cut >= 0 || !jn) drive(1'b0, 1'b0, cut < 0);
        drive(1'b0, 1'b0, 1'b0);
        chk({nm, ":avail"}, DW'(bus.pkt_avail), DW'(1));
        chk({nm, ":err"}, DW'(bus.pkt_err), DW'(e));
        chk({nm, ":valid"}, DW'(bus.pkt_valid), DW'(e == 0));
        chk({nm, ":pid"}, DW'(bus.pkt_pid), DW'(pb[3:0]));
        if (e == 0) begin
            chk({nm, ":len"}, DW'(bus.pkt_len), DW'(dt ? (n - 16) / 8 : 0));
            chk({nm, ":token"}, DW'(bus.pkt_token), DW'(xt));
            chk({nm, ":data"}, bus.pkt_data, xd);
        end
        repeat ($urandom_range(2, 4)) drive(1'b0, 1'b0, 1'b0);
        chk({nm, ":hold"}, DW'(bus.pkt_err), DW'(e));
        chk({nm, ":pulses"}, DW'(npulse - st), DW'(1));
    endtask

    initial begin
        int st;
        logic [7:0] c3, pb;
        logic [3:0] p;
        c3 = 8'hC3;
        bus.bstr = 1'b0;
        bus.bstr_avail = 1'b0;
        bus.bstr_done = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        chk({"rst0", ":avail"}, DW'(bus.pkt_avail), '0);
        chk_zero("rst0");
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);

        body.delete(); run_pkt("ack", 1'b0, 8'hD2, -1);
        body.delete(); add_byte(8'h00); add_byte(8'h10); run_pkt("setup", 1'b0, 8'h2D, -1);
        body.delete(); add_byte(8'h00); add_byte(8'h11); run_pkt("setup_crc", 1'b0, 8'h2D, -1);
        body.delete(); add_byte(8'h00); add_byte(8'h00); run_pkt("data0_z", 1'b0, 8'hC3, -1);
        body.delete(); add_byte(8'h01); add_byte(8'h02); add_crc(1'b1); run_pkt("data0_2", 1'b0, 8'hC3, -1);
        body.delete(); run_pkt("pid_bad", 1'b0, 8'hD3, -1);
        body.delete(); add_byte(8'h00); add_byte(8'h10); void'(body.pop_back()); run_pkt("tok15", 1'b0, 8'h2D, -1);
        body.delete(); repeat (MDB + 3) add_byte(8'($urandom)); run_pkt("ovf", 1'b0, 8'hC3, -1);
        body.delete(); add_byte(8'h5A); add_byte(8'hA5); run_pkt("abort", 1'b0, 8'hC3, 5);

        st = npulse;
        for (int i = 0; i < 8; i++) drive(1'b1, i == 7, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b1, c3[i], 1'b0);
        repeat (5) drive(1'b1, 1'($urandom), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        bus.bstr_avail = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        chk_zero("rst_mid");
        chk("rst_mid:pulses", DW'(npulse - st), '0);

        body.delete(); run_pkt("ack2", 1'b0, 8'hD2, -1);
        body.delete(); run_pkt("sync", 1'b1, 8'hD2, -1);

        st = npulse;
        drive(1'b0, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        chk("idle_done:pulses", DW'(npulse - st), '0);

        for (int k = 0; k < 150; k++) begin
            int kind;
            kind = $urandom_range(0, 3);
            body.delete();
            if (kind == 0) p = hs_p[2'($urandom_range(0, 3))];
            else if (kind == 1) begin
                p = tk_p[3'($urandom_range(0, 4))];
                repeat (11) body.push_back(1'($urandom));
                add_crc(1'b0);
            end else if (kind == 2) begin
                p = dt_p[2'($urandom_range(0, 3))];
                repeat (8 * $urandom_range(0, MDB + 1)) body.push_back(1'($urandom));
                add_crc(1'b1);
            end else begin
                p = 4'($urandom);
                repeat ($urandom_range(0, 24)) body.push_back(1'($urandom));
            end
            pb = {~p, p};
            if ($urandom_range(0, 7) == 0) pb[3'($urandom_range(0, 7))] ^= 1'b1;
            if (body.size() > 0 && $urandom_range(0, 5) == 0) body[$urandom_range(0, body.size() - 1)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                if (body.size() == 0 || $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 9)) body.push_back(1'($urandom));
                else void'(body.pop_back());
            end
            run_pkt("rnd", $urandom_range(0, 9) == 0, pb, $urandom_range(0, 9) == 0 ? $urandom_range(0, body.size()) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
